lzrw1_group_packer: RTL and testbench

- Downstream of the compressed-value stage. Consumes one compressed item per handshake: a literal byte, or a copy {length, offset}.
- Packs the items into LZRW1 groups: a 16-bit control word, then that group's item bytes, sent out as a byte stream with valid/ready.
- Feeds the output buffer / memory writer.
- Removes the fixed 4096-byte array. Storage is bounded to one group.

---
 rtl/lzrw1_pkg.sv | 22 ++
 rtl/lzrw1_group_buf.sv | 31 +++
 rtl/lzrw1_group_packer.sv | 188 ++++++++++++++++++
 tb/tb_lzrw1_group_packer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 compression back end.
package lzrw1_pkg;

  localparam int unsigned LZRW1_MAX_OFFSET = 4095;
  localparam int unsigned LZRW1_CTRL_BITS  = 16;

  typedef enum logic [2:0] {
    COLLECT,
    CTRL_LO,
    CTRL_HI,
    DATA,
    DONE
  } packer_state_e;

  typedef struct packed {
    logic        is_copy;
    logic [7:0]  literal;
    logic [3:0]  length;
    logic [11:0] offset;
  } comp_item_t;

endpackage

// File: rtl/lzrw1_group_buf.sv
// Item-byte store for one LZRW1 group: 1- or 2-byte write, asynchronous read.
module lzrw1_group_buf #(
  parameter int unsigned BUF_BYTES = 32
) (
  input  logic                         clock,
  input  logic                         wr_en,
  input  logic                         wr_two,
  input  logic [$clog2(BUF_BYTES)-1:0] wr_ptr,
  input  logic [7:0]                   wr_data0,
  input  logic [7:0]                   wr_data1,
  input  logic [$clog2(BUF_BYTES)-1:0] rd_addr,
  output logic [7:0]                   rd_data
);

  localparam int unsigned AW = $clog2(BUF_BYTES);

  logic [7:0] mem [BUF_BYTES];

  // Write one byte, or two consecutive bytes for a copy item.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data0;
      if (wr_two) begin
        mem[wr_ptr + AW'(1)] <= wr_data1;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lzrw1_group_packer.sv
// Packs compressed items into LZRW1 groups: 16-bit control word followed by
// the group's item bytes, emitted as a valid/ready byte stream.
module lzrw1_group_packer
  import lzrw1_pkg::*;
#(
  parameter int unsigned GROUP_ITEMS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_copy,
  input  logic [7:0]  in_literal,
  input  logic [3:0]  in_length,
  input  logic [11:0] in_offset,
  input  logic        in_last,
  input  logic        flush,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        out_last,
  output logic        done
);

  localparam int unsigned BUF_BYTES = 2 * GROUP_ITEMS;
  localparam int unsigned AW        = $clog2(BUF_BYTES);
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned CW        = $clog2(GROUP_ITEMS) + 1;

  packer_state_e              state_q, state_d;
  logic [CW-1:0]              item_cnt_q, item_cnt_d;
  logic [PW-1:0]              byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LZRW1_CTRL_BITS-1:0] ctrl_q, ctrl_d;
  logic                       last_grp_q, last_grp_d;

  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       done_q, done_d;

  comp_item_t item;
  logic       accept;
  logic       fire;
  logic       last_byte;
  logic       wr_en;
  logic [7:0] wr_data0;
  logic [7:0] rd_data;

  assign item = '{is_copy: in_is_copy, literal: in_literal, length: in_length,
                  offset: in_offset};

  // in_ready_q is only ever high in COLLECT, so it alone qualifies acceptance.
  assign accept    = in_valid && in_ready_q;
  assign fire      = out_valid_q && out_ready;
  assign last_byte = (rd_ptr_q == byte_cnt_q - PW'(1));
  assign wr_data0  = item.is_copy ? {item.length, item.offset[11:8]} : item.literal;

  lzrw1_group_buf #(
    .BUF_BYTES(BUF_BYTES)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_two  (item.is_copy),
    .wr_ptr  (byte_cnt_q[AW-1:0]),
    .wr_data0(wr_data0),
    .wr_data1(item.offset[7:0]),
    .rd_addr (rd_ptr_d[AW-1:0]),
    .rd_data (rd_data)
  );

  // Next-state, counters and buffer write control.
  always_comb begin
    state_d    = state_q;
    item_cnt_d = item_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    ctrl_d     = ctrl_q;
    last_grp_d = last_grp_q;
    wr_en      = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_en      = 1'b1;
          ctrl_d     = ctrl_q | (LZRW1_CTRL_BITS'(item.is_copy) << item_cnt_q);
          item_cnt_d = item_cnt_q + CW'(1);
          byte_cnt_d = byte_cnt_q + (item.is_copy ? PW'(2) : PW'(1));
          // A flush alongside an item makes that item the stream's last.
          if (item_cnt_d == CW'(GROUP_ITEMS) || in_last || flush) begin
            state_d    = CTRL_LO;
            last_grp_d = in_last || flush;
          end
        end else if (flush && in_ready_q) begin
          if (item_cnt_q != '0) begin
            state_d    = CTRL_LO;
            last_grp_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      CTRL_LO: begin
        if (fire) state_d = CTRL_HI;
      end
      CTRL_HI: begin
        if (fire) begin
          state_d  = DATA;
          rd_ptr_d = '0;
        end
      end
      DATA: begin
        if (fire) begin
          if (!last_byte) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end else if (last_grp_q) begin
            state_d = DONE;
          end else begin
            state_d    = COLLECT;
            item_cnt_d = '0;
            byte_cnt_d = '0;
            rd_ptr_d   = '0;
            ctrl_d     = '0;
            last_grp_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    in_ready_d  = (state_d == COLLECT);
    out_valid_d = (state_d == CTRL_LO) || (state_d == CTRL_HI) || (state_d == DATA);
    done_d      = (state_d == DONE);
    out_last_d  = (state_d == DATA) && last_grp_d && (rd_ptr_d == byte_cnt_d - PW'(1));
    out_data_d  = 8'h00;
    unique case (state_d)
      CTRL_LO: out_data_d = ctrl_d[7:0];
      CTRL_HI: out_data_d = ctrl_d[15:8];
      DATA:    out_data_d = rd_data;
      default: out_data_d = 8'h00;
    endcase
  end

  // State, counters and output registers; synchronous reset drops any group.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= COLLECT;
      item_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      ctrl_q      <= '0;
      last_grp_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_cnt_q  <= item_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      ctrl_q      <= ctrl_d;
      last_grp_q  <= last_grp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Scoreboard bench for lzrw1_group_packer: a group-level model turns accepted
// items into expected bytes; a monitor checks every output handshake.
module tb_lzrw1_group_packer;

  localparam int G = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_copy = 1'b0;
  logic [7:0]  in_literal = 8'h00;
  logic [3:0]  in_length = 4'h0;
  logic [11:0] in_offset = 12'h000;
  logic        in_last = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        done;

  lzrw1_group_packer #(.GROUP_ITEMS(G)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_is_copy(in_is_copy),
    .in_literal(in_literal),
    .in_length (in_length),
    .in_offset (in_offset),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit        is_copy;
    bit [7:0]  lit;
    bit [3:0]  len;
    bit [11:0] off;
  } m_item_t;

  m_item_t    grp[$];
  logic [8:0] exp_q[$];   // {last, data}

  int       rmode = 0;    // 0: ready high, 1: random, 2: 1-0-0-1 pattern
  bit [3:0] pat = 4'b1001;
  int       pi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: emit a whole group as control word plus item bytes.
  function automatic void m_close(bit last);
    int unsigned ctrl = 0;
    bit [7:0]    b[$];
    for (int i = 0; i < grp.size(); i++) begin
      if (grp[i].is_copy) begin
        ctrl += (1 << i);
        b.push_back({grp[i].len, grp[i].off[11:8]});
        b.push_back(grp[i].off[7:0]);
      end else begin
        b.push_back(grp[i].lit);
      end
    end
    exp_q.push_back({1'b0, ctrl[7:0]});
    exp_q.push_back({1'b0, ctrl[15:8]});
    for (int i = 0; i < b.size(); i++) exp_q.push_back({last && (i == b.size() - 1), b[i]});
    grp.delete();
  endfunction

  function automatic void m_accept(m_item_t it, bit last);
    grp.push_back(it);
    if (grp.size() == G || last) m_close(last);
  endfunction

  function automatic void m_flush();
    if (grp.size() > 0) m_close(1'b1);
  endfunction

  // out_ready driver.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rmode)
        1:       out_ready = 1'($urandom % 2);
        2: begin out_ready = pat[pi]; pi = (pi + 1) % 4; end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare every output handshake against the scoreboard.
  initial begin
    logic       pv, pr, pl, e_last;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 0; pr = 0; pl = 0; pd = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pv = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_last", out_last, pl);
      end
      if (out_valid) chk("in_ready_while_out", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          e_last = e[8];
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e_last);
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end
  end

  task automatic do_reset();
    in_valid = 0; flush = 0; in_last = 0;
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    exp_q.delete();
    grp.delete();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    @(posedge clock);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  // Present an item (optionally with flush), wait for acceptance, update model.
  task automatic send_item(input bit is_copy, input bit [7:0] lit, input bit [3:0] len,
                           input bit [11:0] off, input bit last, input bit with_flush);
    m_item_t it;
    bit ok = 0;
    it.is_copy = is_copy; it.lit = lit; it.len = len; it.off = off;
    in_valid = 1; in_is_copy = is_copy; in_literal = lit; in_length = len;
    in_offset = off; in_last = last; flush = with_flush;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      @(posedge clock);
      m_accept(it, last || with_flush);
    end
    #1;
    in_valid = 0; in_last = 0; flush = 0;
  endtask

  task automatic send_flush();
    bit ok = 0;
    flush = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL flush_timeout: got in_ready=0 expected 1");
    end else begin
      @(posedge clock);
      m_flush();
    end
    #1;
    flush = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clock);
    end
    n_checks++; n_fail++;
    $display("FAIL drain_timeout: got %0d pending bytes expected 0", exp_q.size());
  endtask

  task automatic finish_stream();
    wait_drain();
    @(posedge clock);
    #1;
    chk("done_set", done, 1);
    chk("done_out_valid", out_valid, 0);
  endtask

  initial begin
    int n, ending;
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ending;
    do_reset();

    // 16 literals 0x41..0x50, last on the 16th.
    rmode = 0;
    for (int i = 0; i < 16; i++) send_item(0, 8'(8'h41 + i), 0, 0, i == 15, 0);
    finish_stream();
    // Items are ignored once done.
    in_valid = 1; in_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("done_in_ready", in_ready, 0);
      chk("done_no_out", out_valid, 0);
    end
    in_valid = 0; in_last = 0;

    // Copy then literal with last; first ctrl byte one cycle after acceptance.
    do_reset();
    send_item(1, 0, 4'h3, 12'h2A5, 0, 0);
    send_item(0, 8'h7E, 0, 0, 1, 0);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_ctrl_lo", out_data, 8'h01);
    finish_stream();

    // 16 worst-case copies, then a second group.
    do_reset();
    for (int i = 0; i < 16; i++) send_item(1, 0, 4'hF, 12'hFFF, 0, 0);
    wait_drain();
    @(posedge clock);
    #1;
    chk("regroup_in_ready", in_ready, 1);
    chk("regroup_done", done, 0);
    send_item(0, 8'h5A, 0, 0, 1, 0);
    finish_stream();

    // Output stalls 1-0-0-1.
    do_reset();
    rmode = 2;
    for (int i = 0; i < 8; i++) send_item(i[0], 8'(8'hC0 + i), 4'(i), 12'(12'h123 * i), i == 7, 0);
    finish_stream();
    rmode = 0;

    // 5 literals then flush.
    do_reset();
    for (int i = 0; i < 5; i++) send_item(0, 8'(8'h10 + i), 0, 0, 0, 0);
    send_flush();
    chk("flush_out_valid", out_valid, 1);
    finish_stream();

    // Flush with empty group.
    do_reset();
    send_flush();
    chk("empty_flush_done", done, 1);
    chk("empty_flush_out", out_valid, 0);

    // Reset during CTRL_HI of a 3-item group.
    do_reset();
    for (int i = 0; i < 3; i++) send_item(0, 8'(8'hA0 + i), 0, 0, i == 2, 0);
    @(posedge clock);
    #1;
    chk("ctrl_hi_valid", out_valid, 1);
    chk("ctrl_hi_data", out_data, 8'h00);
    do_reset();
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_done", done, 0);
    send_item(0, 8'h11, 0, 0, 1, 0);
    finish_stream();

    // Random streams against the group model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      rmode = 1;
      n = 20 + int'($urandom % 40);
      ending = int'($urandom % 3);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom % 3) begin @(posedge clock); #1; end
        send_item(1'($urandom % 2), 8'($urandom), 4'($urandom), 12'($urandom),
                  (ending == 0) && (i == n - 1), (ending == 1) && (i == n - 1));
      end
      if (ending == 2) send_flush();
      finish_stream();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
